// File: rtl/minicpu_pkg.sv
// ============================================================================
// Module   : minicpu_pkg
// Brief    : Shared widths, opcodes and program-memory state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package minicpu_pkg;

    localparam int         DEF_PROG_W      = 8;
    localparam int         DEF_ADDR_W      = 4;
    localparam logic [7:0] PM_DEFAULT_WORD = 8'hF0;

    // Opcodes live in the upper nibble; the lower nibble is the immediate.
    localparam logic [3:0] ADD_A_IM = 4'h0;
    localparam logic [3:0] MOV_A_B  = 4'h1;
    localparam logic [3:0] IN_A     = 4'h2;
    localparam logic [3:0] MOV_A_IM = 4'h3;
    localparam logic [3:0] MOV_B_A  = 4'h4;
    localparam logic [3:0] ADD_B_IM = 4'h5;
    localparam logic [3:0] IN_B     = 4'h6;
    localparam logic [3:0] MOV_B_IM = 4'h7;
    localparam logic [3:0] OUT_B    = 4'h9;
    localparam logic [3:0] OUT_IM   = 4'hB;
    localparam logic [3:0] JNC      = 4'hE;
    localparam logic [3:0] JMP      = 4'hF;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } pm_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_mem_array.sv
// ============================================================================
// Module   : prog_mem_array
// Brief    : Single-port word array, synchronous write and registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mem_array
    import minicpu_pkg::*;
#(
    parameter int PROG_W = DEF_PROG_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [PROG_W-1:0] i_wdata,
    output logic [PROG_W-1:0] o_rdata
);

    logic [PROG_W-1:0] r_mem [DEPTH];
    logic [PROG_W-1:0] r_rdata;

    // Read data only updates on a read so the last fetch is held.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/prog_mem.sv
// ============================================================================
// Module   : prog_mem
// Brief    : Loadable, self-clearing program memory for the minicpu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mem
    import minicpu_pkg::*;
#(
    parameter int                PROG_W       = DEF_PROG_W,
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                DEPTH        = 2**ADDR_W,
    parameter logic [PROG_W-1:0] DEFAULT_WORD = PROG_W'(PM_DEFAULT_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_en,
    output logic [PROG_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              cpu_hold,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [PROG_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count
);

    localparam logic [ADDR_W-1:0] c_last_wp = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_depth   = (ADDR_W + 1)'(DEPTH);

    pm_state_t         r_state;
    pm_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W:0]   r_load_count;
    logic              r_fetch_valid;
    logic              r_use_dflt;
    logic              r_load_done;

    logic              w_oob;
    logic              w_load_fin;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [PROG_W-1:0] w_mem_wdata;
    logic [PROG_W-1:0] w_mem_rdata;

    assign w_oob      = {1'b0, fetch_addr} >= c_depth;
    assign w_load_fin = (r_state == LOAD) && load_valid && (load_last || (r_wp == c_last_wp));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR: if (r_wp == c_last_wp) w_state_nxt = RUN;
            RUN:   if (load_start)        w_state_nxt = LOAD;
            LOAD:  if (w_load_fin)        w_state_nxt = RUN;
            default:                      w_state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        cpu_hold    = (r_state != RUN);
        load_ready  = (r_state == LOAD);
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_addr  = r_wp;
        w_mem_wdata = DEFAULT_WORD;
        case (r_state)
            CLEAR: w_mem_we = 1'b1;
            RUN: begin
                w_mem_addr = fetch_addr;
                w_mem_re   = fetch_en && !w_oob;
            end
            LOAD: begin
                w_mem_we    = load_valid;
                w_mem_wdata = load_data;
            end
            default: ;
        endcase
    end

    // r_use_dflt masks the array output while held or after an out-of-range fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp          <= '0;
            r_load_count  <= '0;
            r_fetch_valid <= 1'b0;
            r_use_dflt    <= 1'b1;
            r_load_done   <= 1'b0;
        end else begin
            r_load_done   <= w_load_fin;
            r_fetch_valid <= (r_state == RUN) && fetch_en;
            case (r_state)
                CLEAR: begin
                    r_use_dflt <= 1'b1;
                    r_wp       <= (r_wp == c_last_wp) ? '0 : r_wp + 1'b1;
                end
                RUN: begin
                    if (fetch_en) begin
                        r_use_dflt <= w_oob;
                    end
                    if (load_start) begin
                        r_wp         <= '0;
                        r_load_count <= '0;
                    end
                end
                LOAD: begin
                    r_use_dflt <= 1'b1;
                    if (load_valid) begin
                        r_wp <= w_load_fin ? '0 : r_wp + 1'b1;
                        if (r_load_count != c_depth) begin
                            r_load_count <= r_load_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    prog_mem_array #(
        .PROG_W (PROG_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign fetch_data  = r_use_dflt ? DEFAULT_WORD : w_mem_rdata;
    assign fetch_valid = r_fetch_valid;
    assign load_done   = r_load_done;
    assign load_count  = r_load_count;

endmodule

`default_nettype wire

// File: tb/tb_prog_mem.sv
// ============================================================================
// Module   : tb_prog_mem
// Brief    : Directed/random bench for prog_mem against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_mem;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fetch_addr;
    logic       fetch_en;
    logic [7:0] fetch_data;
    logic       fetch_valid;
    logic       cpu_hold;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       load_done;
    logic [4:0] load_count;

    always #5 clk = ~clk;

    prog_mem dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_addr  (fetch_addr),
        .fetch_en    (fetch_en),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .cpu_hold    (cpu_hold),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_count  (load_count)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] ref_mem [DEPTH];
    bit         m_loading;
    int         m_wp;
    int         m_count;
    logic [7:0] img6 [6] = '{8'h70, 8'h20, 8'h01, 8'h40, 8'h90, 8'hF5};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hF0;
        m_loading = 1'b0;
        m_wp      = 0;
        m_count   = 0;
    endtask

    task automatic do_reset;
        int cyc;
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; fetch_en = 1'b0;
        tick;
        tick;
        check("rst_fetch_data", fetch_data, 8'hF0);
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_load_ready", load_ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_count", load_count, 0);
        rst = 1'b0;
        model_clear();
        cyc = 0;
        while (cpu_hold === 1'b1 && cyc < 100) begin
            tick;
            cyc++;
        end
        check("clear_cycles", cyc, DEPTH);
        check("hold_after_clear", cpu_hold, 0);
    endtask

    task automatic fetch_all;
        for (int a = 0; a < DEPTH; a++) begin
            fetch_en   = 1'b1;
            fetch_addr = 4'(a);
            tick;
            check("fetch_valid", fetch_valid, 1);
            check("fetch_data", fetch_data, ref_mem[a]);
        end
        fetch_en = 1'b0;
        tick;
        check("idle_fetch_valid", fetch_valid, 0);
        check("idle_fetch_hold", fetch_data, ref_mem[DEPTH-1]);
    endtask

    task automatic load_begin(input bit with_fetch, input logic [3:0] addr);
        load_start = 1'b1;
        fetch_en   = with_fetch;
        fetch_addr = addr;
        tick;
        load_start = 1'b0;
        fetch_en   = 1'b0;
        m_loading  = 1'b1;
        m_wp       = 0;
        m_count    = 0;
        check("start_hold", cpu_hold, 1);
        check("start_ready", load_ready, 1);
        check("start_count", load_count, 0);
        check("start_fetch_valid", fetch_valid, with_fetch);
        if (with_fetch) check("start_fetch_data", fetch_data, ref_mem[addr]);
    endtask

    task automatic load_words(input int n, input bit mark_last, input bit gaps, input bit fixed);
        logic [7:0] d;
        bit         done;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                load_valid = 1'b0;
                load_data  = 8'($urandom_range(0, 255));
                fetch_en   = m_loading ? 1'($urandom_range(0, 1)) : 1'b0;
                fetch_addr = 4'($urandom_range(0, 15));
                check("gap_ready", load_ready, m_loading);
                tick;
                check("gap_count", load_count, m_count);
                check("gap_done", load_done, 0);
                check("gap_hold", cpu_hold, m_loading);
                check("gap_fetch_valid", fetch_valid, 0);
            end
            d = fixed ? img6[i] : 8'($urandom_range(0, 255));
            check("word_ready", load_ready, m_loading);
            load_valid = 1'b1;
            load_data  = d;
            load_last  = mark_last && (i == n - 1);
            fetch_en   = m_loading ? 1'($urandom_range(0, 1)) : 1'b0;
            fetch_addr = 4'($urandom_range(0, 15));
            tick;
            done = 1'b0;
            if (m_loading) begin
                ref_mem[m_wp] = d;
                m_count++;
                if (load_last || m_wp == DEPTH - 1) begin
                    m_loading = 1'b0;
                    done      = 1'b1;
                    m_wp      = 0;
                end else begin
                    m_wp++;
                end
            end
            check("word_done", load_done, done);
            check("word_count", load_count, m_count);
            check("word_hold", cpu_hold, m_loading);
            check("load_fetch_valid", fetch_valid, 0);
            check("load_fetch_data", fetch_data, 8'hF0);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_en   = 1'b0;
        tick;
        check("done_cleared", load_done, 0);
    endtask

    initial begin
        rst = 1'b1; fetch_addr = '0; fetch_en = 1'b0; load_start = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        model_clear();

        do_reset();
        fetch_all();

        load_begin(1'b0, 4'd0);
        load_words(6, 1'b1, 1'b0, 1'b1);
        check("img6_count", load_count, 6);
        fetch_all();

        load_begin(1'b0, 4'd0);
        load_words(5, 1'b1, 1'b1, 1'b0);
        fetch_all();

        load_begin(1'b0, 4'd0);
        load_words(20, 1'b0, 1'b0, 1'b0);
        check("sat_count", load_count, DEPTH);
        fetch_all();

        load_begin(1'b0, 4'd0);
        load_words(3, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("abort_count", load_count, 0);
        fetch_all();

        load_begin(1'b0, 4'd0);
        load_words(8, 1'b1, 1'b0, 1'b0);
        load_begin(1'b1, 4'd5);
        load_words(2, 1'b1, 1'b0, 1'b0);
        fetch_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
